axis_acq_sequencer: RTL and testbench
=====================================

Name: axis_acq_sequencer

Overview:
- Controls one circular-buffer acquisition: a circular packetizer feeding a wrapping RAM writer.
- Runs the cycle arm → flush → pre-trigger fill → armed → post-trigger capture → done.
- Drives the packetizer's local reset, length and trigger. Latches the packetizer's start position and converts it into buffer addresses for software readout.
- Sits between the AXI-lite config/status registers and the packetizer.

Parameters:
- CNTR_WIDTH, 32, width of the packetizer counter, start position and length fields.
- BUF_AW, 16, log2 of the circular buffer depth in beats; address arithmetic is modulo 2^BUF_AW.
- RST_CYCLES, 2, number of cycles pkt_aresetn is held low during FLUSH (must be ≥1).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- cfg_post_len  in  CNTR_WIDTH  post-trigger length; the packetizer passes cfg_post_len+1 beats after trigger
- cfg_pre_len  in  BUF_AW  minimum pre-trigger beats accepted before the trigger is honoured
- ctrl_arm  in  1  start an acquisition; edge-detected internally
- ctrl_abort  in  1  level; forces FLUSH then IDLE
- ctrl_trig_sw  in  1  software trigger; edge-detected
- ext_trig  in  1  external trigger, synchronous to aclk; rising edge is used
- mon_tvalid  in  1  tap of packetizer m_axis_tvalid
- mon_tready  in  1  tap of packetizer m_axis_tready
- mon_tlast  in  1  tap of packetizer m_axis_tlast
- pkt_start_pos  in  CNTR_WIDTH  packetizer start_pos
- pkt_aresetn  out  1  packetizer reset
- pkt_cfg_data  out  CNTR_WIDTH  packetizer length
- pkt_trigger  out  1  packetizer trigger (level, sticky)
- sts_state  out  3  FSM state encoding
- sts_trig_pos  out  BUF_AW  buffer address of the first post-trigger beat
- sts_oldest  out  BUF_AW  address of the oldest valid beat
- sts_wrapped  out  1  buffer was overwritten at least once
- busy  out  1  high when state ≠ IDLE/DONE
- done_irq  out  1  one-cycle pulse on entry to DONE

Behaviour:
- States and encoding: IDLE=0, FLUSH=1, PREFILL=2, ARMED=3, CAPTURE=4, DONE=5.
- Reset values: state IDLE; pkt_aresetn 0; pkt_trigger 0; pkt_cfg_data 0; all sts_* 0; busy 0; done_irq 0.
- A beat is counted when mon_tvalid & mon_tready.
- IDLE: pkt_aresetn held low.
  - ctrl_arm rising edge → FLUSH.
  - pkt_cfg_data is latched from cfg_post_len on arm and held constant until the next arm.
- FLUSH: pkt_aresetn=0 for RST_CYCLES cycles, pkt_trigger=0, pre-fill counter cleared.
  - Then → PREFILL, with pkt_aresetn=1 from the first PREFILL cycle.
- PREFILL: pre-fill counter increments per beat, saturating at 2^BUF_AW-1.
  - When counter ≥ cfg_pre_len → ARMED on the next cycle.
  - cfg_pre_len=0 goes straight to ARMED after one PREFILL cycle.
  - Trigger edges here are ignored, not queued.
- ARMED: on the first rising edge of ext_trig OR ctrl_trig_sw, pkt_trigger goes 1 on the next cycle and stays 1 → CAPTURE.
  - The pre-fill counter keeps counting, for the wrap decision.
- CAPTURE: a beat with mon_tlast → DONE the next cycle.
  - Latch sts_trig_pos = pkt_start_pos[BUF_AW-1:0] (start_pos is frozen once trigger is high).
  - sts_oldest = sts_wrapped ? (trig_pos + cfg_post_len + 1) mod 2^BUF_AW : 0.
  - sts_wrapped = (pre-fill beats + cfg_post_len + 1) > 2^BUF_AW. Compute at CNTR_WIDTH+1 bits, no overflow.
- DONE: pkt_aresetn stays 1 and pkt_trigger stays 1 (packetizer remains stopped); status held.
  - ctrl_arm edge → FLUSH. A new arm clears status on FLUSH entry.
- Abort: ctrl_abort in any non-IDLE state → FLUSH, then IDLE (abort flag); status cleared; no done_irq.
  - Abort takes priority over arm, trigger and tlast in the same cycle.
- Same-cycle tlast and arm in CAPTURE: tlast wins; the arm is dropped.
- aresetn low mid-operation: return to reset values in the next cycle.

Optional Feature:
- Macro: ACQ_TIMESTAMP_EN.
  - Defined: adds a 64-bit free-running cycle counter (reset 0, wraps) and output port sts_trig_time[63:0], latched on the cycle pkt_trigger rises and cleared on FLUSH.
  - Undefined: neither the port nor the counter exists.

Decomposition:
- Package acq_seq_pkg holds:
  - the state enum (3-bit encoding above)
  - function addr_wrap(pos, len) returning (pos+len+1) mod 2^BUF_AW
- One sub-module, acq_edge_detect: registered rising-edge detector, instantiated three times (arm, trig_sw, ext_trig).

Test Plan:
- BUF_AW=4, cfg_pre_len=3, cfg_post_len=5; arm; 10 beats; ext_trig; stream → pkt_trigger rises 1 cycle after the edge; tlast on the 6th post beat; done_irq once; sts_trig_pos=pkt_start_pos mod 16; sts_wrapped=0; sts_oldest=0.
- Same config with 20 pre-trigger beats → sts_wrapped=1; sts_oldest=(trig_pos+6) mod 16.
- Trigger pulse during PREFILL (1 beat of 3) → ignored; state stays 2 then 3; a second trigger in ARMED is accepted.
- ctrl_abort asserted in CAPTURE simultaneous with tlast → FLUSH, pkt_aresetn low 2 cycles, then IDLE; no done_irq; status 0.
- cfg_pre_len=0, arm then immediate ctrl_trig_sw → FLUSH(2), PREFILL(1), ARMED, trigger honoured.
- aresetn low mid-CAPTURE → all outputs at reset values the next cycle; with ACQ_TIMESTAMP_EN, sts_trig_time=0.

Source files
------------

// File: rtl/acq_seq_pkg.sv
// rtl/acq_seq_pkg.sv - state encoding and buffer address helper for the acquisition sequencer
package acq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_PREFILL = 3'd2,
    ST_ARMED   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } acq_state_t;

  localparam int unsigned ADDR_CALC_W = 64;

  // Address just past a run of len+1 beats starting at pos, modulo 2^aw.
  function automatic logic [ADDR_CALC_W-1:0] addr_wrap(
    input logic [ADDR_CALC_W-1:0] pos,
    input logic [ADDR_CALC_W-1:0] len,
    input int unsigned            aw
  );
    logic [ADDR_CALC_W-1:0] mask;
    if (aw >= ADDR_CALC_W) mask = '1;
    else                   mask = (ADDR_CALC_W'(1) << aw) - ADDR_CALC_W'(1);
    return (pos + len + ADDR_CALC_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/acq_edge_detect.sv
// rtl/acq_edge_detect.sv - registered rising-edge detector for synchronous control inputs
module acq_edge_detect (
  input  logic aclk,
  input  logic aresetn,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) din_q <= 1'b0;
    else          din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/axis_acq_sequencer.sv
// rtl/axis_acq_sequencer.sv - circular-buffer acquisition sequencer; ACQ_TIMESTAMP_EN adds sts_trig_time
module axis_acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int CNTR_WIDTH = 32,
  parameter int BUF_AW     = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_post_len,
  input  logic [BUF_AW-1:0]     cfg_pre_len,
  input  logic                  ctrl_arm,
  input  logic                  ctrl_abort,
  input  logic                  ctrl_trig_sw,
  input  logic                  ext_trig,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  input  logic [CNTR_WIDTH-1:0] pkt_start_pos,
  output logic                  pkt_aresetn,
  output logic [CNTR_WIDTH-1:0] pkt_cfg_data,
  output logic                  pkt_trigger,
  output logic [2:0]            sts_state,
  output logic [BUF_AW-1:0]     sts_trig_pos,
  output logic [BUF_AW-1:0]     sts_oldest,
  output logic                  sts_wrapped,
  output logic                  busy,
  output logic                  done_irq
`ifdef ACQ_TIMESTAMP_EN
  ,
  output logic [63:0]           sts_trig_time
`endif
);

  localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SUM_W     = CNTR_WIDTH + 1;

  acq_state_t state_q, state_d;

  logic arm_rise, trig_sw_rise, ext_trig_rise, trig_rise, beat;
  logic [RST_CNT_W-1:0] flush_cnt_q;
  logic flush_done, abort_q, flush_entry, arm_entry, capture_end;
  logic [BUF_AW-1:0] pre_cnt_q;
  logic [SUM_W-1:0]  span;
  logic              wrap_now;
  logic [BUF_AW-1:0] trig_pos_now, oldest_now;
  logic              unused_start_pos;

  acq_edge_detect u_arm_edge  (.aclk(aclk), .aresetn(aresetn), .din(ctrl_arm),     .rise(arm_rise));
  acq_edge_detect u_sw_edge   (.aclk(aclk), .aresetn(aresetn), .din(ctrl_trig_sw), .rise(trig_sw_rise));
  acq_edge_detect u_ext_edge  (.aclk(aclk), .aresetn(aresetn), .din(ext_trig),     .rise(ext_trig_rise));

  assign trig_rise  = trig_sw_rise | ext_trig_rise;
  assign beat       = mon_tvalid & mon_tready;
  assign flush_done = (flush_cnt_q == RST_CNT_W'(RST_CYCLES - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Abort is checked first in every active state so it beats arm, trigger and tlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm_rise) state_d = ST_FLUSH;
      ST_FLUSH:   if (flush_done) state_d = (abort_q || ctrl_abort) ? ST_IDLE : ST_PREFILL;
      ST_PREFILL: if (ctrl_abort) state_d = ST_FLUSH;
                  else if (pre_cnt_q >= cfg_pre_len) state_d = ST_ARMED;
      ST_ARMED:   if (ctrl_abort) state_d = ST_FLUSH;
                  else if (trig_rise) state_d = ST_CAPTURE;
      ST_CAPTURE: if (ctrl_abort) state_d = ST_FLUSH;
                  else if (beat && mon_tlast) state_d = ST_DONE;
      ST_DONE:    if (ctrl_abort || arm_rise) state_d = ST_FLUSH;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_aresetn = 1'b0;
    pkt_trigger = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_FLUSH:             busy = 1'b1;
      ST_PREFILL, ST_ARMED: begin pkt_aresetn = 1'b1; busy = 1'b1; end
      ST_CAPTURE:           begin pkt_aresetn = 1'b1; pkt_trigger = 1'b1; busy = 1'b1; end
      ST_DONE:              begin pkt_aresetn = 1'b1; pkt_trigger = 1'b1; end
      default:              ;
    endcase
  end

  assign sts_state   = state_q;
  assign flush_entry = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
  assign arm_entry   = flush_entry && ((state_q == ST_IDLE) || !ctrl_abort);
  assign capture_end = (state_q == ST_CAPTURE) && (state_d == ST_DONE);

  // Wrap decision needs one extra bit so pre-fill + post_len + 1 cannot overflow.
  assign span         = SUM_W'(pre_cnt_q) + SUM_W'(pkt_cfg_data) + SUM_W'(1);
  assign wrap_now     = span > (SUM_W'(1) << BUF_AW);
  assign trig_pos_now = pkt_start_pos[BUF_AW-1:0];
  assign oldest_now   = wrap_now ? BUF_AW'(addr_wrap(ADDR_CALC_W'(trig_pos_now),
                                                     ADDR_CALC_W'(pkt_cfg_data), BUF_AW))
                                 : '0;
  assign unused_start_pos = ^pkt_start_pos;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      flush_cnt_q  <= '0;
      abort_q      <= 1'b0;
      pre_cnt_q    <= '0;
      pkt_cfg_data <= '0;
      sts_trig_pos <= '0;
      sts_oldest   <= '0;
      sts_wrapped  <= 1'b0;
      done_irq     <= 1'b0;
    end else begin
      flush_cnt_q <= (state_q == ST_FLUSH) ? flush_cnt_q + RST_CNT_W'(1) : '0;

      if (flush_entry)                             abort_q <= (state_q != ST_IDLE) && ctrl_abort;
      else if (state_q == ST_FLUSH && ctrl_abort)  abort_q <= 1'b1;

      if (state_q == ST_FLUSH)
        pre_cnt_q <= '0;
      else if ((state_q == ST_PREFILL || state_q == ST_ARMED) && beat && (pre_cnt_q != '1))
        pre_cnt_q <= pre_cnt_q + BUF_AW'(1);

      if (arm_entry) pkt_cfg_data <= cfg_post_len;

      if (flush_entry) begin
        sts_trig_pos <= '0;
        sts_oldest   <= '0;
        sts_wrapped  <= 1'b0;
      end else if (capture_end) begin
        sts_trig_pos <= trig_pos_now;
        sts_oldest   <= oldest_now;
        sts_wrapped  <= wrap_now;
      end

      done_irq <= capture_end;
    end
  end

`ifdef ACQ_TIMESTAMP_EN
  logic [63:0] cycle_cnt_q, trig_time_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cycle_cnt_q <= 64'd0;
      trig_time_q <= 64'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 64'd1;
      if (flush_entry)                                     trig_time_q <= 64'd0;
      else if (state_q == ST_ARMED && state_d == ST_CAPTURE) trig_time_q <= cycle_cnt_q;
    end
  end

  assign sts_trig_time = trig_time_q;
`endif

endmodule

// File: tb/tb_axis_acq_sequencer.sv
// tb/tb_axis_acq_sequencer.sv - directed and randomized bench for axis_acq_sequencer with a reference model
module tb_axis_acq_sequencer;

  localparam int CW = 32;
  localparam int AW = 4;
  localparam int RC = 2;
  localparam longint DEPTH = 64'd1 << AW;
  localparam int S_IDLE = 0, S_FLUSH = 1, S_PREFILL = 2, S_ARMED = 3, S_CAPTURE = 4, S_DONE = 5;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg_post_len;
  logic [AW-1:0] cfg_pre_len;
  logic          ctrl_arm, ctrl_abort, ctrl_trig_sw, ext_trig;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic [CW-1:0] pkt_start_pos;
  logic          pkt_aresetn, pkt_trigger, sts_wrapped, busy, done_irq;
  logic [CW-1:0] pkt_cfg_data;
  logic [2:0]    sts_state;
  logic [AW-1:0] sts_trig_pos, sts_oldest;
`ifdef ACQ_TIMESTAMP_EN
  logic [63:0]   sts_trig_time;
`endif

  always #5 aclk = ~aclk;

  axis_acq_sequencer #(.CNTR_WIDTH(CW), .BUF_AW(AW), .RST_CYCLES(RC)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_post_len(cfg_post_len), .cfg_pre_len(cfg_pre_len),
    .ctrl_arm(ctrl_arm), .ctrl_abort(ctrl_abort), .ctrl_trig_sw(ctrl_trig_sw), .ext_trig(ext_trig),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .pkt_start_pos(pkt_start_pos),
    .pkt_aresetn(pkt_aresetn), .pkt_cfg_data(pkt_cfg_data), .pkt_trigger(pkt_trigger),
    .sts_state(sts_state), .sts_trig_pos(sts_trig_pos), .sts_oldest(sts_oldest),
    .sts_wrapped(sts_wrapped), .busy(busy), .done_irq(done_irq)
`ifdef ACQ_TIMESTAMP_EN
    , .sts_trig_time(sts_trig_time)
`endif
  );

  int checks = 0;
  int failures = 0;
  int irq_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the observable acquisition phase and status, advanced once per clock.
  int          m_st = S_IDLE, m_flush = 0, m_pre = 0, m_tpos = 0, m_old = 0;
  longint      m_cfg = 0;
  bit          m_abort = 0, m_wrap = 0, m_irq = 0, m_valid = 0;
  bit          p_arm = 0, p_sw = 0, p_ext = 0, arm_e, trig_e, beat;
  logic [63:0] m_cyc = 0, m_ttime = 0;

  function automatic int sat_inc(input int v);
    return (v + 1 > DEPTH - 1) ? int'(DEPTH - 1) : v + 1;
  endfunction

  task automatic go_flush(input bit aborting, input bit latch_cfg);
    m_st = S_FLUSH; m_flush = 0; m_abort = aborting;
    if (latch_cfg) m_cfg = cfg_post_len;
    m_tpos = 0; m_old = 0; m_wrap = 0; m_ttime = 0;
  endtask

  always @(posedge aclk) begin
    arm_e  = ctrl_arm && !p_arm;
    trig_e = (ctrl_trig_sw && !p_sw) || (ext_trig && !p_ext);
    beat   = mon_tvalid && mon_tready;
    m_valid = 1;
    if (!aresetn) begin
      m_st = S_IDLE; m_flush = 0; m_pre = 0; m_cfg = 0; m_abort = 0;
      m_tpos = 0; m_old = 0; m_wrap = 0; m_irq = 0; m_cyc = 0; m_ttime = 0;
      p_arm = 0; p_sw = 0; p_ext = 0;
    end else begin
      p_arm = ctrl_arm; p_sw = ctrl_trig_sw; p_ext = ext_trig;
      m_irq = 0;
      case (m_st)
        S_IDLE: if (arm_e) go_flush(0, 1);
        S_FLUSH: begin
          if (ctrl_abort) m_abort = 1;
          m_pre = 0;
          m_flush++;
          if (m_flush == RC) m_st = m_abort ? S_IDLE : S_PREFILL;
        end
        S_PREFILL:
          if (ctrl_abort) go_flush(1, 0);
          else begin
            if (m_pre >= int'(cfg_pre_len)) m_st = S_ARMED;
            if (beat) m_pre = sat_inc(m_pre);
          end
        S_ARMED:
          if (ctrl_abort) go_flush(1, 0);
          else begin
            if (trig_e) begin m_st = S_CAPTURE; m_ttime = m_cyc; end
            if (beat) m_pre = sat_inc(m_pre);
          end
        S_CAPTURE:
          if (ctrl_abort) go_flush(1, 0);
          else if (beat && mon_tlast) begin
            m_st   = S_DONE;
            m_irq  = 1;
            m_tpos = int'(longint'(pkt_start_pos) % DEPTH);
            m_wrap = (longint'(m_pre) + m_cfg + 1) > DEPTH;
            m_old  = m_wrap ? int'((longint'(m_tpos) + m_cfg + 1) % DEPTH) : 0;
          end
        S_DONE:
          if (ctrl_abort) go_flush(1, 0);
          else if (arm_e) go_flush(0, 1);
        default: m_st = S_IDLE;
      endcase
      m_cyc++;
    end
  end

  always @(negedge aclk) begin
    if (m_valid) begin
      chk("state", 64'(sts_state), 64'(m_st));
      chk("pkt_aresetn", 64'(pkt_aresetn), 64'(m_st >= S_PREFILL));
      chk("pkt_trigger", 64'(pkt_trigger), 64'(m_st == S_CAPTURE || m_st == S_DONE));
      chk("busy", 64'(busy), 64'(m_st != S_IDLE && m_st != S_DONE));
      chk("pkt_cfg_data", 64'(pkt_cfg_data), 64'(m_cfg));
      chk("trig_pos", 64'(sts_trig_pos), 64'(m_tpos));
      chk("oldest", 64'(sts_oldest), 64'(m_old));
      chk("wrapped", 64'(sts_wrapped), 64'(m_wrap));
      chk("done_irq", 64'(done_irq), 64'(m_irq));
`ifdef ACQ_TIMESTAMP_EN
      chk("trig_time", sts_trig_time, m_ttime);
`endif
      if (done_irq === 1'b1) irq_count++;
    end
  end

  task automatic cyc();
    @(negedge aclk);
    #1;
  endtask

  task automatic pulse_arm();
    ctrl_arm = 1; cyc(); ctrl_arm = 0;
  endtask

  task automatic wait_state(input int st, input int max_cycles);
    int n = 0;
    while (sts_state !== 3'(st) && n < max_cycles) begin cyc(); n++; end
    chk("reach_state", 64'(sts_state), 64'(st));
  endtask

  task automatic beats(input int n);
    mon_tvalid = 1; mon_tready = 1;
    repeat (n) cyc();
    mon_tvalid = 0; mon_tready = 0;
  endtask

  task automatic post_beats(input int n);
    for (int i = 0; i < n; i++) begin
      mon_tvalid = 1; mon_tready = 1; mon_tlast = (i == n - 1);
      cyc();
    end
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
  endtask

  initial begin
    int irq0;
    aresetn = 0; cfg_post_len = 5; cfg_pre_len = 3;
    ctrl_arm = 0; ctrl_abort = 0; ctrl_trig_sw = 0; ext_trig = 0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; pkt_start_pos = 0;
    repeat (3) cyc();
    chk("rst_state", 64'(sts_state), 0);
    chk("rst_pkt_aresetn", 64'(pkt_aresetn), 0);
    chk("rst_busy", 64'(busy), 0);
    aresetn = 1;
    cyc();

    // Basic acquisition, no wrap.
    pkt_start_pos = 32'h1234_5677;
    pulse_arm();
    chk("arm_to_flush", 64'(sts_state), 1);
    wait_state(S_PREFILL, 10);
    beats(10);
    chk("armed_after_fill", 64'(sts_state), 3);
    ext_trig = 1; cyc(); ext_trig = 0;
    chk("trig_one_cycle", 64'(pkt_trigger), 1);
    irq0 = irq_count;
    post_beats(6);
    chk("done_state", 64'(sts_state), 5);
    chk("done_irq_pulse", 64'(done_irq), 1);
    chk("trig_pos_lit", 64'(sts_trig_pos), 7);
    chk("wrapped_lit", 64'(sts_wrapped), 0);
    chk("oldest_lit", 64'(sts_oldest), 0);
    chk("model_oldest_lit", 64'(m_old), 0);
    cyc(); cyc();
    chk("irq_once", 64'(irq_count - irq0), 1);

    // Long pre-fill wraps the buffer.
    pkt_start_pos = 32'h0000_00AC;
    pulse_arm();
    wait_state(S_PREFILL, 10);
    beats(20);
    ext_trig = 1; cyc(); ext_trig = 0;
    post_beats(6);
    chk("wrap_lit", 64'(sts_wrapped), 1);
    chk("wrap_oldest_lit", 64'(sts_oldest), 2);
    chk("wrap_trig_pos_lit", 64'(sts_trig_pos), 12);
    chk("model_wrap_oldest_lit", 64'(m_old), 2);

    // Trigger during pre-fill is dropped; a later one in ARMED is taken.
    pulse_arm();
    wait_state(S_PREFILL, 10);
    mon_tvalid = 1; mon_tready = 1; ext_trig = 1; cyc(); ext_trig = 0;
    chk("prefill_ignore_trig", 64'(sts_state), 2);
    wait_state(S_ARMED, 10);
    mon_tvalid = 0; mon_tready = 0;
    chk("armed_no_trig", 64'(pkt_trigger), 0);
    ctrl_trig_sw = 1; cyc(); ctrl_trig_sw = 0;
    chk("sw_trig_capture", 64'(sts_state), 4);

    // Abort together with tlast in CAPTURE.
    irq0 = irq_count;
    ctrl_abort = 1; mon_tvalid = 1; mon_tready = 1; mon_tlast = 1; cyc();
    ctrl_abort = 0; mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    chk("abort_flush1", 64'(sts_state), 1);
    chk("abort_rst1", 64'(pkt_aresetn), 0);
    cyc();
    chk("abort_flush2", 64'(sts_state), 1);
    chk("abort_rst2", 64'(pkt_aresetn), 0);
    cyc();
    chk("abort_idle", 64'(sts_state), 0);
    chk("abort_status", 64'({sts_trig_pos, sts_oldest, sts_wrapped}), 0);
    chk("abort_no_irq", 64'(irq_count - irq0), 0);

    // Zero pre-fill length: one PREFILL cycle then ARMED.
    cfg_pre_len = 0;
    pulse_arm();
    chk("p0_flush1", 64'(sts_state), 1);
    cyc(); chk("p0_flush2", 64'(sts_state), 1);
    cyc(); chk("p0_prefill", 64'(sts_state), 2);
    cyc(); chk("p0_armed", 64'(sts_state), 3);
    ctrl_trig_sw = 1; cyc(); ctrl_trig_sw = 0;
    chk("p0_capture", 64'(sts_state), 4);
    post_beats(1);
    chk("p0_done", 64'(sts_state), 5);

    // Reset in the middle of CAPTURE.
    pulse_arm();
    wait_state(S_ARMED, 10);
    ext_trig = 1; cyc(); ext_trig = 0;
    aresetn = 0; cyc();
    chk("mid_rst_state", 64'(sts_state), 0);
    chk("mid_rst_outs", 64'({pkt_aresetn, pkt_trigger, busy, done_irq, sts_wrapped}), 0);
    chk("mid_rst_cfg", 64'(pkt_cfg_data), 0);
`ifdef ACQ_TIMESTAMP_EN
    chk("mid_rst_time", sts_trig_time, 0);
`endif
    aresetn = 1; cyc();

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      ctrl_arm     = ($urandom_range(0, 99) < 8);
      ctrl_abort   = ($urandom_range(0, 199) < 3);
      ext_trig     = ($urandom_range(0, 99) < 6);
      ctrl_trig_sw = ($urandom_range(0, 99) < 4);
      mon_tvalid   = ($urandom_range(0, 99) < 75);
      mon_tready   = ($urandom_range(0, 99) < 75);
      mon_tlast    = ($urandom_range(0, 99) < 15);
      aresetn      = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 39) == 0) cfg_pre_len = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0)
        cfg_post_len = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : CW'($urandom_range(0, 20));
      if (!pkt_trigger) pkt_start_pos = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
